id_ex_stage: RTL and testbench

//  Decode/operand-fetch stage directly upstream of the register file.
//  - Drives regfile read addresses from the incoming instruction.
//  - Captures rd1/rd2, PC, instruction, sign-extended immediate and rd

---
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode / operand-fetch stage sitting directly upstream of the register
//   file. It drives the regfile read addresses from the incoming instruction
//   and captures operands, PC, instruction, sign-extended immediate and
//   destination register into the ID/EX pipeline register.
//
//   Handshake: valid/ready on both sides. A load-use dependency on the
//   held instruction inserts exactly one bubble. flush kills the held
//   instruction and consumes/discards whatever is presented on the input.
//
//   Optional feature macro: ID_WB_BYPASS_EN
//     defined   -> a writeback landing in the same edge as an accept is
//                  forwarded into ex_rs1_val / ex_rs2_val.
//     undefined -> operands are the regfile read data (pre-write values).
//
// Parameters
//   XLEN      datapath / operand width (>= 32)
//   RESET_PC  reset value of ex_pc
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready/in_pc/in_instr  upstream handshake and payload
//   ra1, ra2                        regfile read addresses (combinational)
//   rd1, rd2                        regfile read data
//   wb_we, wb_wa, wb_wd             writeback port (mirrors regfile write)
//   flush                           kill held instruction and input
//   ex_ready/ex_valid               downstream handshake
//   ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_is_load
//                                   ID/EX register contents
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_is_load
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic            hazard;
    logic            accept;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign ra1 = in_instr[19:15];
    assign ra2 = in_instr[24:20];

    // rs2 is compared for every opcode: a spurious stall is harmless,
    // a missed one is not.
    assign hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) & in_valid &
                    ((ex_rd == ra1) | (ex_rd == ra2));

    // During flush the input is always consumed (and dropped).
    assign in_ready = flush | (~hazard & (~ex_valid | ex_ready));
    assign accept   = in_valid & in_ready & ~flush;

    // Immediate is formed at 32 bits, then sign-extended to XLEN.
    always_comb begin
        imm32 = 32'd0;
        case (in_instr[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR:
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_STORE:
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {in_instr[31:12], 12'd0};
            OP_JAL:
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            default:
                imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

`ifdef ID_WB_BYPASS_EN
    // The regfile commits wb_wd on the same edge we capture; take it here
    // so the operand is not one write stale.
    assign op1 = (wb_we && wb_wa != 5'd0 && wb_wa == ra1) ? wb_wd : rd1;
    assign op2 = (wb_we && wb_wa != 5'd0 && wb_wa == ra2) ? wb_wd : rd2;
`else
    // Pre-write values; same-cycle WB forwarding is handled in EX.
    assign op1 = rd1;
    assign op2 = rd2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= RESET_PC;
            ex_instr   <= 32'd0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= 5'd0;
            ex_is_load <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (hazard) begin
            // Load leaves if EX takes it; the dependent input waits a cycle.
            if (ex_ready) ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_pc      <= in_pc;
            ex_instr   <= in_instr;
            ex_rs1_val <= op1;
            ex_rs2_val <= op2;
            ex_imm     <= imm;
            ex_rd      <= in_instr[11:7];
            ex_is_load <= (in_instr[6:0] == OP_LOAD);
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0, wb_we = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0, wb_wd = '0;
    logic [4:0]  wb_wa = '0;
    logic        in_ready, ex_valid, ex_is_load;
    logic [4:0]  ra1, ra2, ex_rd;
    logic [31:0] rd1, rd2, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load)
    );

    // ---------------- bench register file + reference model ----------------
    logic [31:0] rf [32];
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_rs1, m_rs2;

    // Immediate by format, using arithmetic shifts of the signed word.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic signed [31:0] s;
        s = $signed(i);
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return 32'(s >>> 20);
            7'b0100011: return 32'((s >>> 25) <<< 5) | 32'(i[11:7]);
            7'b1100011: return 32'((s >>> 31) <<< 12) | (32'(i[7]) << 11) |
                               (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
            7'b1101111: return 32'((s >>> 31) <<< 20) | (32'(i[19:12]) << 12) |
                               (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_hazard();
        return m_valid && m_instr[6:0] == 7'b0000011 && m_instr[11:7] != 0 &&
               in_valid && (m_instr[11:7] == in_instr[19:15] ||
                            m_instr[11:7] == in_instr[24:20]);
    endfunction

    function automatic logic m_ready();
        return flush || (!m_hazard() && (!m_valid || ex_ready));
    endfunction

    function automatic logic [31:0] fetch(input logic [4:0] a);
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_wa != 0 && wb_wa == a) return wb_wd;
`endif
        return rf[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_pc = RPC; m_instr = '0; m_rs1 = '0; m_rs2 = '0;
            for (int k = 0; k < 32; k++) rf[k] <= '0;
        end else begin
            if (flush) m_valid = 1'b0;
            else if (m_hazard()) begin
                if (ex_ready) m_valid = 1'b0;
            end else if (in_valid && m_ready()) begin
                m_valid = 1'b1; m_pc = in_pc; m_instr = in_instr;
                m_rs1 = fetch(in_instr[19:15]); m_rs2 = fetch(in_instr[24:20]);
            end else if (ex_ready) m_valid = 1'b0;
            if (wb_we && wb_wa != 0) rf[wb_wa] <= wb_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("ra1", 32'(ra1), 32'(in_instr[19:15]));
        chk("ra2", 32'(ra2), 32'(in_instr[24:20]));
        chk("ex_pc", ex_pc, m_pc);
        if (m_valid) begin
            chk("ex_instr", ex_instr, m_instr);
            chk("ex_rs1_val", ex_rs1_val, m_rs1);
            chk("ex_rs2_val", ex_rs2_val, m_rs2);
            chk("ex_imm", ex_imm, ref_imm(m_instr));
            chk("ex_rd", 32'(ex_rd), 32'(m_instr[11:7]));
            chk("ex_is_load", 32'(ex_is_load), 32'(m_instr[6:0] == 7'b0000011));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1; in_pc = pc; in_instr = ins; #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we = we; wb_wa = a; wb_wd = d;
    endtask

    localparam logic [31:0] ADDI_M1 = 32'hFFF0_0293;  // addi x5,x0,-1
    localparam logic [31:0] LW6     = 32'h0000_A303;  // lw x6,0(x1)
    localparam logic [31:0] ADD7    = 32'h0023_03B3;  // add x7,x6,x2
    localparam logic [31:0] ADDI10  = 32'h0050_8513;  // addi x10,x1,5
    localparam logic [31:0] SW      = 32'h0020_A423;  // sw x2,8(x1)
    localparam logic [31:0] BEQ     = 32'hFE00_0EE3;  // beq x0,x0,-4
    localparam logic [31:0] JAL     = 32'h0010_00EF;  // jal x1,2048
    localparam logic [31:0] LUI     = 32'h1234_52B7;  // lui x5,0x12345
    localparam logic [31:0] ADDI8   = 32'h0001_8413;  // addi x8,x3,0
    localparam logic [31:0] ADDI9   = 32'h0000_0493;  // addi x9,x0,0

    initial begin
        logic [31:0] held;
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_pc", ex_pc, RPC);
        chk("rst_ex_imm", ex_imm, 32'd0);
        rst_n = 1'b1;

        // Seed registers through the writeback port.
        wb(1, 5'd1, 32'h0000_1000); tick();
        wb(1, 5'd2, 32'h0000_0022); tick();
        wb(0, 5'd0, 32'd0);

        // addi x5,x0,-1
        ex_ready = 1'b1;
        present(32'h200, ADDI_M1);
        chk("t2_ra1", 32'(ra1), 32'd0);
        tick();
        chk("t2_valid", 32'(ex_valid), 32'd1);
        chk("t2_imm", ex_imm, 32'hFFFF_FFFF);
        chk("t2_rd", 32'(ex_rd), 32'd5);

        // Load-use: one bubble.
        present(32'h204, LW6); tick();
        present(32'h208, ADD7);
        chk("t3_stall_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t3_bubble", 32'(ex_valid), 32'd0);
        tick();
        chk("t3_add_valid", 32'(ex_valid), 32'd1);
        chk("t3_add_instr", ex_instr, ADD7);
        chk("t3_add_rs2", ex_rs2_val, 32'h0000_0022);

        // Backpressure for 3 cycles.
        ex_ready = 1'b0;
        present(32'h20C, ADDI10);
        held = ex_pc;
        for (int c = 0; c < 3; c++) begin
            chk("t4_stall_ready", 32'(in_ready), 32'd0);
            tick();
            chk("t4_hold_pc", ex_pc, held);
        end
        ex_ready = 1'b1; #1;
        chk("t4_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t4_next_instr", ex_instr, ADDI10);
        chk("t4_rs1", ex_rs1_val, 32'h0000_1000);

        // Flush with both input and held instruction valid.
        present(32'h210, SW);
        flush = 1'b1; ex_ready = 1'b0; #1;
        chk("t5_flush_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t5_flushed", 32'(ex_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        tick();
        chk("t5_never_seen", 32'(ex_valid), 32'd0);

        // Immediate formats back to back.
        present(32'h300, SW);   tick();
        chk("imm_s", ex_imm, 32'd8);
        present(32'h304, BEQ);  tick();
        chk("imm_b", ex_imm, 32'hFFFF_FFFC);
        present(32'h308, JAL);  tick();
        chk("imm_j", ex_imm, 32'h0000_0800);
        present(32'h30C, LUI);  tick();
        chk("imm_u", ex_imm, 32'h1234_5000);

        // WB->ID same-edge write.
        present(32'h400, ADDI8);
        wb(1, 5'd3, 32'hDEAD_BEEF);
        tick();
`ifdef ID_WB_BYPASS_EN
        chk("t6_bypass", ex_rs1_val, 32'hDEAD_BEEF);
`else
        chk("t6_nobypass", ex_rs1_val, 32'd0);
`endif
        present(32'h404, ADDI9);
        wb(1, 5'd0, 32'hDEAD_BEEF);
        tick();
        chk("t6_x0", ex_rs1_val, 32'd0);
        wb(0, 5'd0, 32'd0);
        present(32'h408, ADDI8); tick();
        chk("t6_rf_committed", ex_rs1_val, 32'hDEAD_BEEF);

        // Reset mid-stream, between edges.
        present(32'h40C, ADDI10); tick();
        #2 rst_n = 1'b0; #1;
        chk("t1_async_valid", 32'(ex_valid), 32'd0);
        chk("t1_async_pc", ex_pc, RPC);
        tick();
        in_valid = 1'b0; rst_n = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
